// File: rtl/trig_prescale_gate.sv
// Trigger prescale and dead-time gate: edge-detects coincidence triggers, prescales per channel,
// emits fixed-width accepted pulses and keeps raw/accepted/live/total scalers.
module trig_prescale_gate #(
  parameter int NCH         = 9,
  parameter int PS_WIDTH    = 16,
  parameter int OUT_STAGES  = 4,
  parameter int DEAD_CYCLES = 20,
  parameter int CNT_WIDTH   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCH-1:0]          trig_in,
  input  logic [NCH-1:0]          ch_enable,
  input  logic [NCH*PS_WIDTH-1:0] ps_factor,
  input  logic                    busy_in,
  input  logic                    cnt_clr,
  input  logic [3:0]              cnt_sel,
  output logic [NCH-1:0]          trig_out,
  output logic                    trig_any,
  output logic                    dead,
  output logic [CNT_WIDTH-1:0]    cnt_raw,
  output logic [CNT_WIDTH-1:0]    cnt_acc,
  output logic [CNT_WIDTH-1:0]    live_cnt,
  output logic [CNT_WIDTH-1:0]    clk_cnt
);

  localparam int CYC_MAX = (OUT_STAGES > DEAD_CYCLES) ? OUT_STAGES : DEAD_CYCLES;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);
  localparam logic [CYC_W-1:0] OUT_LAST  = CYC_W'(OUT_STAGES - 1);
  localparam logic [CYC_W-1:0] DEAD_LAST = CYC_W'(DEAD_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, FIRE, DEAD, WAIT_BUSY} state_t;

  state_t               state_q, state_d;
  logic [CYC_W-1:0]     cyc_q, cyc_d;
  logic [NCH-1:0]       trig_q;
  logic [NCH-1:0]       pattern_q, pattern_d;
  logic [NCH-1:0]       trig_out_q, trig_out_d;
  logic                 trig_any_q;
  logic                 dead_q, dead_d;
  logic [PS_WIDTH-1:0]  pc_q  [NCH];
  logic [PS_WIDTH-1:0]  pc_d  [NCH];
  logic [CNT_WIDTH-1:0] raw_q [NCH];
  logic [CNT_WIDTH-1:0] raw_d [NCH];
  logic [CNT_WIDTH-1:0] acc_q [NCH];
  logic [CNT_WIDTH-1:0] acc_d [NCH];
  logic [CNT_WIDTH-1:0] live_cnt_q, live_cnt_d;
  logic [CNT_WIDTH-1:0] clk_cnt_q, clk_cnt_d;
  logic [CNT_WIDTH-1:0] rd_raw_q, rd_raw_d;
  logic [CNT_WIDTH-1:0] rd_acc_q, rd_acc_d;
  logic [NCH-1:0]       rise, pass;
  logic                 live;
  logic [PS_WIDTH-1:0]  ps_cur, eff_m1;

  // Prescale and scaler next-state; a clear overrides any coincident increment.
  always_comb begin
    rise   = trig_in & ~trig_q;
    live   = (state_q == IDLE) && !busy_in;
    pass   = '0;
    ps_cur = '0;
    eff_m1 = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      raw_d[i] = raw_q[i];
      acc_d[i] = acc_q[i];
      pc_d[i]  = pc_q[i];
      ps_cur   = ps_factor[i*PS_WIDTH +: PS_WIDTH];
      eff_m1   = (ps_cur == '0) ? '0 : ps_cur - PS_WIDTH'(1);
      if (rise[i] && live && ch_enable[i]) begin
        if (pc_q[i] >= eff_m1) begin
          pass[i] = 1'b1;
          pc_d[i] = '0;
        end else begin
          pc_d[i] = pc_q[i] + PS_WIDTH'(1);
        end
      end
      if (rise[i] && raw_q[i] != '1) raw_d[i] = raw_q[i] + CNT_WIDTH'(1);
      if (pass[i] && acc_q[i] != '1) acc_d[i] = acc_q[i] + CNT_WIDTH'(1);
      if (cnt_clr) begin
        raw_d[i] = '0;
        acc_d[i] = '0;
        pc_d[i]  = '0;
      end
    end
    live_cnt_d = (live && live_cnt_q != '1) ? live_cnt_q + CNT_WIDTH'(1) : live_cnt_q;
    clk_cnt_d  = (clk_cnt_q != '1) ? clk_cnt_q + CNT_WIDTH'(1) : clk_cnt_q;
    if (cnt_clr) begin
      live_cnt_d = '0;
      clk_cnt_d  = '0;
    end
    rd_raw_d = '0;
    rd_acc_d = '0;
    if (int'(cnt_sel) < NCH) begin
      rd_raw_d = raw_q[cnt_sel];
      rd_acc_d = acc_q[cnt_sel];
    end
  end

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    pattern_d  = pattern_q;
    trig_out_d = '0;
    case (state_q)
      IDLE: if (pass != '0) begin
        state_d    = FIRE;
        pattern_d  = pass;
        cyc_d      = '0;
        trig_out_d = pass;
      end
      FIRE: begin
        trig_out_d = pattern_q;
        cyc_d      = cyc_q + CYC_W'(1);
        if (cyc_q == OUT_LAST) begin
          state_d    = DEAD;
          cyc_d      = '0;
          trig_out_d = '0;
        end
      end
      DEAD: begin
        cyc_d = cyc_q + CYC_W'(1);
        if (cyc_q == DEAD_LAST) begin
          state_d = busy_in ? WAIT_BUSY : IDLE;
          cyc_d   = '0;
        end
      end
      WAIT_BUSY: if (!busy_in) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
    // Registered so that dead rises together with the first trig_out cycle.
    dead_d = (state_d != IDLE) || busy_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cyc_q      <= '0;
      trig_q     <= '0;
      pattern_q  <= '0;
      trig_out_q <= '0;
      trig_any_q <= 1'b0;
      dead_q     <= 1'b0;
      live_cnt_q <= '0;
      clk_cnt_q  <= '0;
      rd_raw_q   <= '0;
      rd_acc_q   <= '0;
      for (int unsigned i = 0; i < NCH; i++) begin
        pc_q[i]  <= '0;
        raw_q[i] <= '0;
        acc_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      trig_q     <= trig_in;
      pattern_q  <= pattern_d;
      trig_out_q <= trig_out_d;
      trig_any_q <= |trig_out_d;
      dead_q     <= dead_d;
      live_cnt_q <= live_cnt_d;
      clk_cnt_q  <= clk_cnt_d;
      rd_raw_q   <= rd_raw_d;
      rd_acc_q   <= rd_acc_d;
      for (int unsigned i = 0; i < NCH; i++) begin
        pc_q[i]  <= pc_d[i];
        raw_q[i] <= raw_d[i];
        acc_q[i] <= acc_d[i];
      end
    end
  end

  assign trig_out = trig_out_q;
  assign trig_any = trig_any_q;
  assign dead     = dead_q;
  assign cnt_raw  = rd_raw_q;
  assign cnt_acc  = rd_acc_q;
  assign live_cnt = live_cnt_q;
  assign clk_cnt  = clk_cnt_q;

endmodule

// File: tb/tb_trig_prescale_gate.sv
// Bench for trig_prescale_gate: directed vector table, hand-written corner sequences and
// random stimulus, all checked every cycle against a timeline-based reference model.
module tb_trig_prescale_gate;
  localparam int NCH  = 9;
  localparam int PSW  = 16;
  localparam int OUTS = 4;
  localparam int DEADC = 20;

  logic             clk = 1'b0;
  logic             rst;
  logic [NCH-1:0]   trig_in, ch_enable;
  logic [NCH*PSW-1:0] ps_factor;
  logic             busy_in, cnt_clr;
  logic [3:0]       cnt_sel;
  logic [NCH-1:0]   trig_out;
  logic             trig_any, dead;
  logic [31:0]      cnt_raw, cnt_acc, live_cnt, clk_cnt;

  trig_prescale_gate #(.NCH(NCH), .PS_WIDTH(PSW), .OUT_STAGES(OUTS), .DEAD_CYCLES(DEADC),
                       .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .trig_in(trig_in), .ch_enable(ch_enable), .ps_factor(ps_factor),
    .busy_in(busy_in), .cnt_clr(cnt_clr), .cnt_sel(cnt_sel), .trig_out(trig_out),
    .trig_any(trig_any), .dead(dead), .cnt_raw(cnt_raw), .cnt_acc(cnt_acc),
    .live_cnt(live_cnt), .clk_cnt(clk_cnt));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: tracks when the gate next becomes idle as an edge number.
  int          edge_n = 0;
  logic [31:0] m_raw [NCH];
  logic [31:0] m_acc [NCH];
  int          m_since [NCH];
  logic [31:0] m_live, m_clk;
  logic [NCH-1:0] m_prev, m_pattern;
  int          m_acc_edge, m_idle_at;
  bit          m_fired, m_waiting;
  logic [NCH-1:0] e_out;
  logic        e_dead;
  logic [31:0] e_rd_raw, e_rd_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s edge=%0d actual=%0h expected=%0h", name, edge_n, act, exp);
    end
  endtask

  task automatic model_step();
    bit in_idle, live;
    int eff;
    logic [NCH-1:0] passv;
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_raw[i] = 0; m_acc[i] = 0; m_since[i] = 0;
      end
      m_live = 0; m_clk = 0; m_prev = '0; m_pattern = '0;
      m_fired = 0; m_waiting = 0; m_idle_at = edge_n + 1; m_acc_edge = 0;
      e_out = '0; e_dead = 0; e_rd_raw = 0; e_rd_acc = 0;
    end else begin
      in_idle = !m_waiting && edge_n >= m_idle_at;
      live = in_idle && !busy_in;
      e_rd_raw = (cnt_sel < NCH) ? m_raw[cnt_sel] : 0;
      e_rd_acc = (cnt_sel < NCH) ? m_acc[cnt_sel] : 0;
      passv = '0;
      for (int i = 0; i < NCH; i++) begin
        if (trig_in[i] && !m_prev[i]) begin
          if (m_raw[i] != '1) m_raw[i]++;
          if (live && ch_enable[i]) begin
            eff = (ps_factor[i*PSW +: PSW] == 0) ? 1 : int'(ps_factor[i*PSW +: PSW]);
            if (m_since[i] + 1 >= eff) begin
              passv[i] = 1'b1;
              m_since[i] = 0;
              if (m_acc[i] != '1) m_acc[i]++;
            end else m_since[i]++;
          end
        end
      end
      if (live && m_live != '1) m_live++;
      if (m_clk != '1) m_clk++;
      if (cnt_clr) begin
        for (int i = 0; i < NCH; i++) begin
          m_raw[i] = 0; m_acc[i] = 0; m_since[i] = 0;
        end
        m_live = 0; m_clk = 0;
      end
      m_prev = trig_in;
      if (passv != '0) begin
        m_fired = 1; m_acc_edge = edge_n; m_pattern = passv;
        m_idle_at = edge_n + OUTS + DEADC + 1;
      end else if (m_fired && !m_waiting && edge_n == m_idle_at - 1 && busy_in) begin
        m_waiting = 1;
      end else if (m_waiting && !busy_in) begin
        m_waiting = 0; m_idle_at = edge_n + 1;
      end
      e_out  = (m_fired && edge_n - m_acc_edge < OUTS) ? m_pattern : '0;
      e_dead = !(!m_waiting && edge_n + 1 >= m_idle_at) || busy_in;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("trig_out", 32'(trig_out), 32'(e_out));
    chk("trig_any", 32'(trig_any), 32'(|e_out));
    chk("dead", 32'(dead), 32'(e_dead));
    chk("cnt_raw", cnt_raw, e_rd_raw);
    chk("cnt_acc", cnt_acc, e_rd_acc);
    chk("live_cnt", live_cnt, m_live);
    chk("clk_cnt", clk_cnt, m_clk);
    edge_n++;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic pulse(input logic [NCH-1:0] mask);
    trig_in = trig_in | mask;
    step(); step();
    trig_in = trig_in & ~mask;
  endtask

  task automatic set_ps_all(input int v);
    for (int i = 0; i < NCH; i++) ps_factor[i*PSW +: PSW] = PSW'(v);
  endtask

  task automatic do_reset();
    trig_in = '0; busy_in = 0; cnt_clr = 0; cnt_sel = 0; ch_enable = '1; set_ps_all(1);
    rst = 1; step(); step(); rst = 0;
  endtask

  task automatic rd(input int ch, input int er, input int ea, input string name);
    cnt_sel = 4'(ch);
    step();
    chk({name, "_raw"}, cnt_raw, 32'(er));
    chk({name, "_acc"}, cnt_acc, 32'(ea));
  endtask

  typedef struct {
    int ch; int ps; bit en; int npulse; int gap; int exp_raw; int exp_acc;
  } vec_t;
  vec_t tbl[5];

  initial begin
    int ones, dh, nz, lc0, cc0;
    tbl[0] = '{ch: 0, ps: 1, en: 1, npulse: 1,  gap: 40, exp_raw: 1,  exp_acc: 1};
    tbl[1] = '{ch: 3, ps: 4, en: 1, npulse: 12, gap: 40, exp_raw: 12, exp_acc: 3};
    tbl[2] = '{ch: 2, ps: 1, en: 0, npulse: 5,  gap: 40, exp_raw: 5,  exp_acc: 0};
    tbl[3] = '{ch: 7, ps: 0, en: 1, npulse: 3,  gap: 30, exp_raw: 3,  exp_acc: 3};
    tbl[4] = '{ch: 5, ps: 3, en: 1, npulse: 7,  gap: 10, exp_raw: 7,  exp_acc: 1};

    for (int v = 0; v < 5; v++) begin
      do_reset();
      ps_factor[tbl[v].ch*PSW +: PSW] = PSW'(tbl[v].ps);
      ch_enable[tbl[v].ch] = tbl[v].en;
      for (int p = 0; p < tbl[v].npulse; p++) begin
        pulse(NCH'(1) << tbl[v].ch);
        idle(tbl[v].gap - 2);
      end
      idle(30);
      rd(tbl[v].ch, tbl[v].exp_raw, tbl[v].exp_acc, $sformatf("vec%0d", v));
    end

    // Pulse width and dead window after a single accept
    do_reset();
    ones = 0; dh = 0;
    trig_in = 9'h001;
    for (int j = 0; j < 30; j++) begin
      step();
      if (j == 0) chk("latency", 32'(trig_out), 32'h001);
      if (j == 1) trig_in = '0;
      ones += int'(trig_out[0]);
      dh += int'(dead);
    end
    chk("pulse_width", 32'(ones), 32'(OUTS));
    chk("dead_width", 32'(dh), 32'(OUTS + DEADC));

    // Edge inside dead time must not advance the prescaler
    do_reset();
    ps_factor[1*PSW +: PSW] = 2;
    pulse(9'h001); idle(8);
    pulse(9'h002); idle(40);
    rd(1, 1, 0, "dead_edge");
    pulse(9'h002); idle(40);
    rd(1, 2, 0, "pc_hold");
    pulse(9'h002); idle(40);
    rd(1, 3, 1, "pc_pass");

    // Simultaneous rises
    do_reset();
    trig_in = 9'h021;
    step();
    chk("simul", 32'(trig_out), 32'h021);
    step(); trig_in = '0; idle(30);
    rd(0, 1, 1, "simul0");
    rd(5, 1, 1, "simul5");

    // Busy veto holds the gate after dead time
    do_reset();
    pulse(9'h001); idle(2);
    busy_in = 1;
    lc0 = int'(live_cnt); cc0 = int'(clk_cnt); nz = 0; dh = 0;
    for (int j = 0; j < 100; j++) begin
      if (j == 30 || j == 60) trig_in[1] = 1'b1;
      if (j == 32 || j == 62) trig_in[1] = 1'b0;
      step();
      if (trig_out != '0) nz++;
      dh += int'(dead);
    end
    chk("busy_no_out", 32'(nz), 0);
    chk("busy_dead", 32'(dh), 100);
    chk("busy_live_frozen", live_cnt, 32'(lc0));
    chk("busy_clk_adv", clk_cnt, 32'(cc0 + 100));
    busy_in = 0; step();
    pulse(9'h002); idle(30);
    rd(1, 3, 1, "after_busy");

    // Clear coincident with a rise
    do_reset();
    pulse(9'h001); idle(30);
    trig_in = 9'h001; cnt_clr = 1;
    step();
    cnt_clr = 0;
    chk("clr_clk", clk_cnt, 0);
    chk("clr_live", live_cnt, 0);
    step(); trig_in = '0;
    rd(0, 0, 0, "clr");

    // Reset in the middle of a pulse
    do_reset();
    pulse(9'h004);
    chk("fire_before_rst", 32'(trig_out), 32'h004);
    rst = 1; step(); rst = 0;
    chk("rst_trig_out", 32'(trig_out), 0);
    chk("rst_clk", clk_cnt, 0);
    chk("rst_dead", 32'(dead), 0);
    idle(5);
    rd(2, 0, 0, "rst_cnt");

    // Random traffic
    do_reset();
    for (int j = 0; j < 3000; j++) begin
      if (j % 500 == 0) begin
        ch_enable = NCH'($urandom);
        for (int i = 0; i < NCH; i++) ps_factor[i*PSW +: PSW] = PSW'($urandom_range(0, 3));
      end
      trig_in = NCH'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 39) == 0) busy_in = ~busy_in;
      cnt_clr = ($urandom_range(0, 199) == 0);
      rst = ($urandom_range(0, 999) == 0);
      cnt_sel = 4'($urandom_range(0, 15));
      step();
    end
    rst = 0; cnt_clr = 0; busy_in = 0; trig_in = '0;
    rd(12, 0, 0, "sel12");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
